// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types, constants and helpers for the ALU execution controller
package alu_pkg;

  localparam int SIZE_DEFAULT = 8;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions inside the 4-bit {V,C,N,Z} flag word
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // ALU operand-select codes; the ALU adds the selected B term to A plus carry-in
  typedef enum logic [2:0] {
    ALU_ZERO     = 3'b000,
    ALU_ONE      = 3'b001,
    ALU_B        = 3'b010,
    ALU_B_INC    = 3'b011,
    ALU_B_NOT    = 3'b100,
    ALU_B_NEG    = 3'b101,
    ALU_ALL_ONES = 3'b110,
    ALU_ZERO_ALT = 3'b111
  } alu_code_t;

  // Assemble individual ALU status bits into the flag word by named index
  function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                            input logic n, input logic z);
    logic [3:0] f;
    f         = '0;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_status_reg.sv
// rtl/alu_status_reg.sv - accumulator and {V,C,N,Z} flag register with flag-only writes
module alu_status_reg
  import alu_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            flag_only,
  input  logic [SIZE-1:0] result_in,
  input  logic [3:0]      flags_in,
  output logic [SIZE-1:0] acc_out,
  output logic [3:0]      flags_out
);

  logic [SIZE-1:0] acc_q, acc_d;
  logic [3:0]      flags_q, flags_d;

  // Flags always take the new value on a write; the accumulator is skipped for flag-only ops
  always_comb begin
    acc_d   = acc_q;
    flags_d = flags_q;
    if (wr_en) begin
      flags_d = flags_in;
      if (!flag_only) begin
        acc_d = result_in;
      end
    end
  end

  // Storage registers, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

  assign acc_out   = acc_q;
  assign flags_out = flags_q;

endmodule

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - ALU sequencer: accept, execute, write back; ACC_FORWARD_EN enables accumulator forwarding
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inValid,
  output logic            inReady,
  input  logic [SIZE-1:0] inA,
  input  logic [SIZE-1:0] inB,
  input  logic [2:0]      inOp,
  input  logic            inUseAcc,
  input  logic            inFlagOnly,
  output logic [SIZE-1:0] aluA,
  output logic [SIZE-1:0] aluB,
  output logic [2:0]      aluCode,
  output logic            aluCarryIn,
  input  logic [SIZE-1:0] aluResult,
  input  logic            aluV,
  input  logic            aluC,
  input  logic            aluN,
  input  logic            aluZ,
  output logic [SIZE-1:0] accOut,
  output logic [3:0]      flagsOut,
  output logic            outValid,
  output logic            busy
);

  state_t          state_q, state_d;
  logic [SIZE-1:0] a_q, a_d;
  logic [SIZE-1:0] b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic            flag_only_q, flag_only_d;
  logic            wr_en;
  logic [SIZE-1:0] a_sel;

  // Source for operand A; forwarding resolves at accept time, when the accumulator
  // still holds the value the op was issued against
`ifdef ACC_FORWARD_EN
  assign a_sel = inUseAcc ? accOut : inA;
`else
  logic unused_use_acc;
  assign unused_use_acc = inUseAcc;
  assign a_sel          = inA;
`endif

  // Next-state, operand latching and handshake outputs
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    flag_only_d = flag_only_q;
    inReady     = 1'b0;
    busy        = 1'b0;
    outValid    = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        inReady = 1'b1;
        if (inValid) begin
          a_d         = a_sel;
          b_d         = inB;
          op_d        = inOp;
          flag_only_d = inFlagOnly;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy     = 1'b1;
        outValid = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-operand registers; reset discards any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      flag_only_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      flag_only_q <= flag_only_d;
    end
  end

  assign aluA       = a_q;
  assign aluB       = b_q;
  assign aluCode    = op_q;
  assign aluCarryIn = flagsOut[FLAG_C];

  alu_status_reg #(
    .SIZE(SIZE)
  ) u_status (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .flag_only (flag_only_q),
    .result_in (aluResult),
    .flags_in  (pack_flags(aluV, aluC, aluN, aluZ)),
    .acc_out   (accOut),
    .flags_out (flagsOut)
  );

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - self-checking bench for alu_exec_ctrl with an ALU stand-in and reference model
module tb_alu_exec_ctrl;

`ifdef ACC_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;
  logic       in_use_acc, in_flag_only;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_code;
  logic       alu_cin, alu_v, alu_c, alu_n, alu_z;
  logic [7:0] acc_out;
  logic [3:0] flags_out;
  logic       out_valid, busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_acc;
  logic [3:0] m_flags;

  always #5 clk = ~clk;

  // ALU: result = A + sel(B) + cin, returns {V,C,N,Z,result}
  function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op, input logic cin);
    logic [7:0] bs;
    logic [8:0] s;
    logic [7:0] r;
    logic       v;
    case (op)
      3'b000:  bs = 8'h00;
      3'b001:  bs = 8'h01;
      3'b010:  bs = b;
      3'b011:  bs = b + 8'd1;
      3'b100:  bs = ~b;
      3'b101:  bs = 8'd0 - b;
      3'b110:  bs = 8'hFF;
      default: bs = 8'h00;
    endcase
    s = {1'b0, a} + {1'b0, bs} + {8'd0, cin};
    r = s[7:0];
    v = (a[7] == bs[7]) && (r[7] != a[7]);
    return {v, s[8], r[7], (r == 8'h00), r};
  endfunction

  assign {alu_v, alu_c, alu_n, alu_z, alu_result} = alu_fn(alu_a, alu_b, alu_code, alu_cin);

  alu_exec_ctrl #(.SIZE(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .inValid    (in_valid),
    .inReady    (in_ready),
    .inA        (in_a),
    .inB        (in_b),
    .inOp       (in_op),
    .inUseAcc   (in_use_acc),
    .inFlagOnly (in_flag_only),
    .aluA       (alu_a),
    .aluB       (alu_b),
    .aluCode    (alu_code),
    .aluCarryIn (alu_cin),
    .aluResult  (alu_result),
    .aluV       (alu_v),
    .aluC       (alu_c),
    .aluN       (alu_n),
    .aluZ       (alu_z),
    .accOut     (acc_out),
    .flagsOut   (flags_out),
    .outValid   (out_valid),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_acc = 8'h00;
    m_flags = 4'h0;
  endtask

  // Issue one op from a negedge; checks handshake timing and writeback against the model.
  // With junk=1 the inputs are scribbled on while busy, which must be ignored.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic ua, input logic fo, input logic junk);
    int n;
    logic [7:0]  aa;
    logic [11:0] r;
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) check("ready_timeout", 32'd1, 32'd0);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    in_use_acc = ua;
    in_flag_only = fo;
    @(posedge clk);
    @(negedge clk);
    if (junk) begin
      in_valid = 1'b1;
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      in_op = 3'($urandom);
      in_flag_only = 1'($urandom);
      in_use_acc = 1'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    check("exec_busy", busy, 1'b1);
    check("exec_ready", in_ready, 1'b0);
    check("exec_outvalid", out_valid, 1'b0);
    aa = (FWD && ua) ? m_acc : a;
    r = alu_fn(aa, b, op, m_flags[2]);
    m_flags = r[11:8];
    if (!fo) m_acc = r[7:0];
    @(negedge clk);
    check("done_outvalid", out_valid, 1'b1);
    check("done_acc", acc_out, m_acc);
    check("done_flags", flags_out, m_flags);
    check("done_alub_hold", alu_b, b);
    @(negedge clk);
    in_valid = 1'b0;
    check("idle_outvalid", out_valid, 1'b0);
    check("idle_ready", in_ready, 1'b1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       fo;
    logic [7:0] exp_acc;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int accepts, pulses, bad;

    vecs[0]  = '{8'h7F, 8'h01, 3'b010, 1'b0, 8'h80, 4'b1010};
    vecs[1]  = '{8'h05, 8'h05, 3'b101, 1'b0, 8'h00, 4'b0101};
    vecs[2]  = '{8'h10, 8'h10, 3'b101, 1'b1, 8'h00, 4'b0100};
    vecs[3]  = '{8'h00, 8'h00, 3'b000, 1'b0, 8'h01, 4'b0000};
    vecs[4]  = '{8'hFF, 8'h00, 3'b001, 1'b0, 8'h00, 4'b0101};
    vecs[5]  = '{8'h80, 8'h7F, 3'b110, 1'b0, 8'h80, 4'b0110};
    vecs[6]  = '{8'h80, 8'hFF, 3'b011, 1'b0, 8'h81, 4'b0010};
    vecs[7]  = '{8'h40, 8'hBF, 3'b100, 1'b0, 8'h80, 4'b1010};
    vecs[8]  = '{8'h12, 8'h34, 3'b111, 1'b0, 8'h12, 4'b0000};
    vecs[9]  = '{8'h00, 8'h80, 3'b101, 1'b0, 8'h80, 4'b0010};
    vecs[10] = '{8'hFF, 8'h01, 3'b010, 1'b0, 8'h00, 4'b0101};
    vecs[11] = '{8'h7F, 8'h00, 3'b011, 1'b0, 8'h81, 4'b1010};

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = 8'h00;
    in_b = 8'h00;
    in_op = 3'b000;
    in_use_acc = 1'b0;
    in_flag_only = 1'b0;
    m_acc = 8'h00;
    m_flags = 4'h0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_outvalid", out_valid, 1'b0);
    check("rst_acc", acc_out, 8'h00);
    check("rst_flags", flags_out, 4'h0);
    check("rst_alua", alu_a, 8'h00);
    check("rst_alub", alu_b, 8'h00);
    check("rst_code", alu_code, 3'b000);
    rst = 1'b0;

    // Table of hand-computed results, applied back to back from reset
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, vecs[i].fo, 1'b0);
      check($sformatf("vec%0d_acc", i), acc_out, vecs[i].exp_acc);
      check($sformatf("vec%0d_flags", i), flags_out, vecs[i].exp_flags);
    end

    // Flag-only update keeps the accumulator
    do_reset();
    do_op(8'h7F, 8'h01, 3'b010, 1'b0, 1'b0, 1'b0);
    check("fo_setup_acc", acc_out, 8'h80);
    do_op(8'h10, 8'h10, 3'b101, 1'b0, 1'b1, 1'b0);
    check("fo_acc_held", acc_out, 8'h80);
    check("fo_flags", flags_out, 4'b0101);

    // Backpressure: inValid held for 6 edges
    do_reset();
    accepts = 0;
    pulses = 0;
    bad = 0;
    in_a = 8'h01;
    in_b = 8'h01;
    in_op = 3'b010;
    in_use_acc = 1'b0;
    in_flag_only = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 6);
      if (in_valid && in_ready) accepts++;
      @(negedge clk);
      if (busy && in_ready) bad++;
      if (out_valid) pulses++;
    end
    check("bp_accepts", accepts, 2);
    check("bp_pulses", pulses, 2);
    check("bp_ready_while_busy", bad, 0);
    check("bp_acc", acc_out, 8'h02);
    m_acc = 8'h02;
    m_flags = 4'h0;

    // Reset while in EXEC discards the op
    in_valid = 1'b1;
    in_a = 8'h7F;
    in_b = 8'h01;
    in_op = 3'b010;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_ready", in_ready, 1'b1);
    check("mid_busy", busy, 1'b0);
    check("mid_outvalid", out_valid, 1'b0);
    check("mid_acc", acc_out, 8'h00);
    check("mid_flags", flags_out, 4'h0);
    @(negedge clk);
    check("mid_no_pulse", out_valid, 1'b0);
    check("mid_acc_held", acc_out, 8'h00);
    rst = 1'b0;
    m_acc = 8'h00;
    m_flags = 4'h0;
    // First edge after reset release accepts
    do_op(8'h7F, 8'h01, 3'b010, 1'b0, 1'b0, 1'b0);
    check("post_rst_acc", acc_out, 8'h80);

    // Accumulator forwarding
    do_reset();
    do_op(8'h03, 8'h00, 3'b010, 1'b0, 1'b0, 1'b0);
    do_op(8'h00, 8'h04, 3'b010, 1'b1, 1'b0, 1'b0);
    check("fwd_acc", acc_out, FWD ? 8'h07 : 8'h04);

    // Randomized ops against the reference model, with junk driven while busy
    do_reset();
    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(negedge clk);
      do_op(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 8, operand/result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have ports inValid (input, 1, op offered) and inReady (output, 1, op can be accepted).
REQ-005 SHALL have ports inA and inB (input, SIZE, operands) and inOp (input, 3, ALU operand-select code).
REQ-006 SHALL have ports inUseAcc (input, 1, take A from accumulator) and inFlagOnly (input, 1, update flags only).
REQ-007 SHALL have ports aluA and aluB (output, SIZE), aluCode (output, 3) and aluCarryIn (output, 1), all driven to the ALU.
REQ-008 SHALL have ports aluResult (input, SIZE) and aluV, aluC, aluN, aluZ (input, 1 each), all returned from the ALU.
REQ-009 SHALL have ports accOut (output, SIZE, accumulator), flagsOut (output, 4, {V,C,N,Z}), outValid (output, 1, one-cycle completion pulse) and busy (output, 1).

Function
REQ-010 SHALL implement FSM states IDLE, EXEC and DONE.
REQ-011 In IDLE, inReady SHALL be 1; an edge with inValid=1 SHALL latch inA, inB, inOp, inUseAcc and inFlagOnly, then go to EXEC.
REQ-012 In EXEC and DONE, inReady SHALL be 0 and busy SHALL be 1; inValid SHALL be ignored, with no latch and no queuing.
REQ-013 In EXEC, aluA/aluB/aluCode SHALL come from latched values; aluCarryIn SHALL be the stored C flag; the ALU path is combinational within EXEC.
REQ-014 On the EXEC->DONE edge, flagsOut SHALL capture {aluV,aluC,aluN,aluZ}; accOut SHALL capture aluResult unless latched inFlagOnly=1, in which case accOut is held.
REQ-015 In DONE, outValid SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-016 Latency SHALL be: accept at edge k, accOut/flagsOut valid after edge k+1, outValid high between edges k+1 and k+2; throughput is one op per 3 cycles.
REQ-017 Outside EXEC, aluA/aluB/aluCode SHALL hold their last latched values; accOut/flagsOut SHALL change only on the EXEC->DONE edge.
REQ-018 SHALL perform no arithmetic; results wrap at SIZE bits inside the ALU and are stored unchanged.

Reset
REQ-019 rst SHALL force IDLE, accOut=0, flagsOut=0, outValid=0, busy=0, inReady=1 and all latched operands/code to 0, at any state including mid-EXEC; an in-flight op is discarded without writeback.
REQ-020 The first rising edge after rst falls SHALL be able to accept an op.

Configuration
REQ-021 With ACC_FORWARD_EN defined, latched inUseAcc=1 SHALL select accOut (value at accept time) as aluA.
REQ-022 Without ACC_FORWARD_EN, inUseAcc SHALL be ignored and aluA SHALL always be the latched inA.

Structure
REQ-023 Shared package alu_pkg SHALL hold SIZE default, FSM state encoding, flag bit indices (V=3,C=2,N=1,Z=0) and named ALU codes: 000 ZERO, 001 ONE, 010 B, 011 B+1, 100 ~B, 101 -B, 110 -1, 111 ZERO.
REQ-024 One sub-module alu_status_reg SHALL hold the accumulator and flags, with write-enable and flag-only controls.

Verification
REQ-025 Add overflow: A=0x7F, B=0x01, op=010 -> accOut=0x80, flagsOut=1010 (V=1,C=0,N=1,Z=0), outValid two edges after accept.
REQ-026 Subtract equal: A=0x05, B=0x05, op=101 -> accOut=0x00, Z=1, C=1, N=0, V=0.
REQ-027 Flag-only: acc=0x80, then A=0x10, B=0x10, op=101, inFlagOnly=1 -> Z=1, accOut stays 0x80.
REQ-028 Backpressure: inValid held high for 6 cycles -> exactly 2 ops accepted, inReady low in EXEC/DONE, outValid pulses 2 times.
REQ-029 Reset mid-EXEC: assert rst while in EXEC -> accOut=0x00, flagsOut=0000, no outValid, inReady=1 immediately.
REQ-030 With ACC_FORWARD_EN: acc=0x03, inUseAcc=1, B=0x04, op=010 -> accOut=0x07; without the macro, inA=0x00 gives accOut=0x04.
